// File: rtl/alu_issue_pkg.sv
// Shared opcode/func encodings, FSM state type and legality decode for alu_issue_ctrl.
package alu_issue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                           (fn == FN_OR)  || (fn == FN_SLT);
            OP_BEQ, OP_ADDI, OP_LW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, r0 hardwired to zero.
module alu_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue IDLE/EXEC/WB controller driving an external ALU for a small MIPS subset.
// Define ILLEGAL_TRAP_EN to make illegal instructions raise a sticky trap that blocks further accepts.
module alu_issue_ctrl
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_func,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        branch_taken,
    output logic [31:0] branch_offset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        trap
);

    state_e      state_q, state_d;
    logic [31:0] instr_q;
    logic [31:0] result_q;
    logic        zero_q;
    logic        trap_q;

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext;
    logic        legal;
    logic [31:0] rs_val, rt_val;
    logic        wr_en;
    logic [4:0]  wr_idx;

    assign op       = instr_q[31:26];
    assign fn       = instr_q[5:0];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rd       = instr_q[15:11];
    assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};
    assign legal    = is_legal(op, fn);

    assign instr_ready = (state_q == S_IDLE) && !trap_q;
    assign trap        = trap_q;

    alu_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rs_val),
        .rd2_o (rt_val),
        .we_i  (wb_valid),
        .wa_i  (wb_rd),
        .wd_i  (wb_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (instr_valid && instr_ready) begin
                instr_q <= instr;
            end
            if (state_q == S_EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Set on the EXEC->WB edge so the flag is already visible during WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else if ((state_q == S_EXEC) && !legal) begin
            trap_q <= 1'b1;
        end
    end
`else
    assign trap_q = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        alu_opcode    = '0;
        alu_func      = '0;
        alu_a         = '0;
        alu_b         = '0;
        branch_taken  = 1'b0;
        branch_offset = '0;
        mem_req       = 1'b0;
        mem_addr      = '0;
        wr_en         = 1'b0;
        wr_idx        = '0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid && instr_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d    = S_WB;
                alu_opcode = op;
                alu_func   = fn;
                alu_a      = rs_val;
                alu_b      = ((op == OP_ADDI) || (op == OP_LW)) ? imm_sext : rt_val;
            end
            S_WB: begin
                state_d = S_IDLE;
                if (legal) begin
                    case (op)
                        OP_RTYPE: begin
                            wr_en  = 1'b1;
                            wr_idx = rd;
                        end
                        OP_ADDI: begin
                            wr_en  = 1'b1;
                            wr_idx = rt;
                        end
                        OP_BEQ: begin
                            branch_taken  = zero_q;
                            branch_offset = imm_sext;
                        end
                        OP_LW: begin
                            mem_req  = 1'b1;
                            mem_addr = result_q;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A write to r0 is dropped entirely, so no pulse is raised for it.
    assign wb_valid = wr_en && (wr_idx != '0);
    assign wb_rd    = wb_valid ? wr_idx : '0;
    assign wb_data  = wb_valid ? result_q : '0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed program plus randomized instructions against a reference model.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [5:0]  alu_opcode;
    logic [5:0]  alu_func;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        trap;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [31:0] mregs [32];

    alu_issue_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .alu_opcode    (alu_opcode),
        .alu_func      (alu_func),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .trap          (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU as seen by the controller.
    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            6'h00: case (alu_func)
                6'h20: alu_result = alu_a + alu_b;
                6'h22: alu_result = alu_a - alu_b;
                6'h24: alu_result = alu_a & alu_b;
                6'h25: alu_result = alu_a | alu_b;
                6'h2A: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
                default: alu_result = '0;
            endcase
            6'h08, 6'h23: alu_result = alu_a + alu_b;
            6'h04: alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_instr(input logic [31:0] ins);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, dst;
        logic [31:0] a, b, sx, res;
        logic        legal, wr, exp_trap;
        int unsigned waited;
        op = ins[31:26];
        fn = ins[5:0];
        rs = ins[25:21];
        rt = ins[20:16];
        rd = ins[15:11];
        sx = {{16{ins[15]}}, ins[15:0]};
        legal = ((op == 6'h00) && ((fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
                 (fn == 6'h25) || (fn == 6'h2A))) || (op == 6'h08) || (op == 6'h04) || (op == 6'h23);
        a = mregs[rs];
        b = ((op == 6'h08) || (op == 6'h23)) ? sx : mregs[rt];
        res = '0;
        if (op == 6'h00) begin
            if (fn == 6'h20) res = a + b;
            else if (fn == 6'h22) res = a - b;
            else if (fn == 6'h24) res = a & b;
            else if (fn == 6'h25) res = a | b;
            else if (fn == 6'h2A) res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        end else if ((op == 6'h08) || (op == 6'h23)) begin
            res = a + b;
        end
        dst = (op == 6'h00) ? rd : rt;
        wr  = legal && ((op == 6'h00) || (op == 6'h08)) && (dst != 5'd0);
`ifdef ILLEGAL_TRAP_EN
        exp_trap = !legal;
`else
        exp_trap = 1'b0;
`endif

        waited = 0;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("instr_ready", {31'b0, instr_ready}, 32'd1);
        if (!instr_ready) return;

        instr_valid = 1'b1;
        instr       = ins;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = $urandom;
        check("exec_opcode", {26'b0, alu_opcode}, {26'b0, op});
        check("exec_func", {26'b0, alu_func}, {26'b0, fn});
        check("exec_a", alu_a, a);
        if (legal) check("exec_b", alu_b, b);
        check("exec_no_wb", {31'b0, wb_valid}, 32'd0);
        check("exec_not_ready", {31'b0, instr_ready}, 32'd0);

        @(negedge clk);
        check("wb_valid", {31'b0, wb_valid}, {31'b0, wr});
        if (wr) begin
            check("wb_rd", {27'b0, wb_rd}, {27'b0, dst});
            check("wb_data", wb_data, res);
        end
        check("branch_taken", {31'b0, branch_taken}, {31'b0, legal && (op == 6'h04) && (a == b)});
        if (legal && (op == 6'h04)) check("branch_offset", branch_offset, sx);
        check("mem_req", {31'b0, mem_req}, {31'b0, legal && (op == 6'h23)});
        if (legal && (op == 6'h23)) check("mem_addr", mem_addr, res);
        check("trap", {31'b0, trap}, {31'b0, exp_trap});
        if (wr) mregs[dst] = res;

        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
    endtask

    function automatic logic [31:0] rand_instr(input logic allow_illegal);
        logic [31:0] w;
        logic [5:0]  fns [5];
        int unsigned k;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
        w = $urandom;
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 8);
        case (k)
            0, 1, 2, 3, 4: begin
                w[31:26] = 6'h00;
                w[15:11] = 5'($urandom_range(0, 7));
                w[5:0]   = fns[k];
            end
            5: w[31:26] = 6'h08;
            6: w[31:26] = 6'h04;
            7: w[31:26] = 6'h23;
            default: begin
                if (allow_illegal) begin
                    w[31:26] = (($urandom & 1) != 0) ? 6'h3F : 6'h00;
                    w[5:0]   = 6'h21;
                end else begin
                    w[31:26] = 6'h08;
                end
            end
        endcase
        return w;
    endfunction

    initial begin
        logic allow_ill;
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, instr_ready}, 32'd1);
        check("rst_trap", {31'b0, trap}, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_instr(32'h2001_2222);
        run_instr(32'h2002_1111);
        run_instr(32'h0022_1820);
        check("r3_value", mregs[3], 32'h3333);
        run_instr(32'h0022_2024);
        run_instr(32'h1021_0004);
        run_instr(32'h0041_282A);
        run_instr(32'h8C22_0010);
        run_instr(32'h0040_3020);
        check("r6_from_r2", mregs[6], 32'h1111);
        run_instr(32'h2000_0005);
        run_instr(32'h0000_3820);
        run_instr(32'h1022_0008);

`ifdef ILLEGAL_TRAP_EN
        allow_ill = 1'b0;
`else
        allow_ill = 1'b1;
`endif
        for (int n = 0; n < 200; n++) begin
            run_instr(rand_instr(allow_ill));
        end

        // Reset asserted while an instruction is in EXEC.
        instr_valid = 1'b1;
        instr       = 32'h2028_0005;
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'b0, instr_ready}, 32'd1);
        check("midrst_alu_a", alu_a, 32'd0);
        @(negedge clk);
        check("midrst_no_wb", {31'b0, wb_valid}, 32'd0);
        clear_model();
        rst_n = 1'b1;
        @(negedge clk);
        run_instr(32'h2029_0007);
        run_instr(32'h0120_5020);

`ifdef ILLEGAL_TRAP_EN
        run_instr(32'hFC00_0000);
        instr_valid = 1'b1;
        instr       = 32'h2001_0001;
        for (int n = 0; n < 5; n++) begin
            check("trap_blocks_ready", {31'b0, instr_ready}, 32'd0);
            check("trap_sticky", {31'b0, trap}, 32'd1);
            check("trap_no_wb", {31'b0, wb_valid}, 32'd0);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        check("trap_cleared", {31'b0, trap}, 32'd0);
        run_instr(32'h2001_0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
